// File: rtl/piso_serializer_if.sv
// Handshake/data bundle between a word source and the serializer.
// The master drives load/d; the serializer (slave) returns the serial line and the burst framing.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] d;
  logic             dout;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output load,
    output d,
    input  dout,
    input  valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  d,
    output dout,
    output valid,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word and shifts it out one bit per clock,
// framed by valid/busy and a one-cycle done pulse. All outputs are registered.
//
//   state | meaning
//   IDLE  | waiting for load; all outputs low
//   SEND  | one data bit per cycle on dout, valid and busy high
//   FIN   | one-cycle done pulse; receiver word is complete in this cycle
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("piso_serializer: WIDTH must be between 2 and 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             dout_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  // dout is loaded with the bit that the shift register will present next, so it stays registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.load) begin
            state   <= SEND;
            sreg    <= bus.d;
            cnt     <= '0;
            dout_q  <= MSB_FIRST ? bus.d[WIDTH-1] : bus.d[0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        SEND: begin
          if (cnt == CNT_LAST) begin
            state   <= FIN;
            sreg    <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
            if (MSB_FIRST) begin
              sreg   <= {sreg[WIDTH-2:0], 1'b0};
              dout_q <= sreg[WIDTH-2];
            end else begin
              sreg   <= {1'b0, sreg[WIDTH-1:1]};
              dout_q <= sreg[1];
            end
          end
        end
        FIN: begin
          state   <= IDLE;
          dout_q  <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          sreg    <= '0;
          cnt     <= '0;
          dout_q  <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializers (4-bit LSB-first, 8-bit MSB-first) driven by directed and
// random bursts; a timing model predicts framing, a bit queue predicts dout, receivers rebuild words.
module tb_piso_serializer;

  localparam int W0 = 4;
  localparam int W1 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W0)) bus0 ();
  piso_serializer_if #(.WIDTH(W1)) bus1 ();

  piso_serializer #(.WIDTH(W0), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  piso_serializer #(.WIDTH(W1), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  int          edge_n  = 0;
  int          acc[2]  = '{-1000, -1000};
  int          next_ok[2] = '{0, 0};
  int          width[2]   = '{W0, W1};
  bit          msbf[2]    = '{1'b0, 1'b1};
  bit          bq0[$];
  bit          bq1[$];
  logic [15:0] wq0[$];
  logic [15:0] wq1[$];

  logic [W0-1:0] rx0;
  logic [W1-1:0] rx1;

  logic o_dout[2], o_valid[2], o_busy[2], o_done[2];
  assign o_dout[0]  = bus0.dout;   assign o_dout[1]  = bus1.dout;
  assign o_valid[0] = bus0.valid;  assign o_valid[1] = bus1.valid;
  assign o_busy[0]  = bus0.busy;   assign o_busy[1]  = bus1.busy;
  assign o_done[0]  = bus0.done;   assign o_done[1]  = bus1.done;

  // receivers: LSB-first into the 4-stage chain, MSB-first for the 8-bit lane
  always @(posedge clk) begin
    rx0 <= {bus0.dout, rx0[W0-1:1]};
    rx1 <= {rx1[W1-2:0], bus1.dout};
  end

  // accept model: a load is taken on an edge at least WIDTH+2 edges after the previous accept
  always @(posedge clk) begin
    edge_n++;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        logic        ld;
        logic [15:0] dv;
        ld = (i == 0) ? bus0.load : bus1.load;
        dv = (i == 0) ? 16'(bus0.d) : 16'(bus1.d);
        if (ld && edge_n >= next_ok[i]) begin
          acc[i]     = edge_n;
          next_ok[i] = edge_n + width[i] + 2;
          for (int b = 0; b < width[i]; b++) begin
            if (i == 0) bq0.push_back(msbf[i] ? dv[width[i]-1-b] : dv[b]);
            else        bq1.push_back(msbf[i] ? dv[width[i]-1-b] : dv[b]);
          end
          if (i == 0) wq0.push_back(dv);
          else        wq1.push_back(dv);
        end
      end
    end
  end

  always @(posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      acc[i]     = -1000;
      next_ok[i] = 0;
    end
    bq0.delete(); bq1.delete();
    wq0.delete(); wq1.delete();
  end

  // monitor
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int          k;
      bit          eb;
      logic [15:0] ew;
      logic [15:0] got;
      if (rst) begin
        check($sformatf("rst_dout%0d", i),  o_dout[i],  1'b0);
        check($sformatf("rst_valid%0d", i), o_valid[i], 1'b0);
        check($sformatf("rst_busy%0d", i),  o_busy[i],  1'b0);
        check($sformatf("rst_done%0d", i),  o_done[i],  1'b0);
      end else begin
        k = edge_n - acc[i];
        check($sformatf("valid%0d", i), o_valid[i], (k >= 0 && k < width[i]));
        check($sformatf("busy%0d", i),  o_busy[i],  (k >= 0 && k <= width[i]));
        check($sformatf("done%0d", i),  o_done[i],  (k == width[i]));
        if (o_valid[i]) begin
          if ((i == 0 ? bq0.size() : bq1.size()) == 0) begin
            check($sformatf("bit_underflow%0d", i), 1, 0);
          end else begin
            eb = (i == 0) ? bq0.pop_front() : bq1.pop_front();
            check($sformatf("dout%0d", i), o_dout[i], eb);
          end
        end else begin
          check($sformatf("dout_idle%0d", i), o_dout[i], 1'b0);
        end
        if (o_done[i]) begin
          if ((i == 0 ? wq0.size() : wq1.size()) == 0) begin
            check($sformatf("word_underflow%0d", i), 1, 0);
          end else begin
            ew  = (i == 0) ? wq0.pop_front() : wq1.pop_front();
            got = (i == 0) ? 16'(rx0) : 16'(rx1);
            check($sformatf("rx_word%0d", i), got, ew & 16'((1 << width[i]) - 1));
            check($sformatf("bits_left%0d", i), (i == 0) ? bq0.size() : bq1.size(), 0);
          end
        end
      end
    end
  end

  task automatic pulse0(logic [W0-1:0] dv, int hold);
    @(negedge clk);
    bus0.load = 1'b1; bus0.d = dv;
    repeat (hold) @(negedge clk);
    bus0.load = 1'b0; bus0.d = W0'($urandom);
  endtask

  initial begin
    bus0.load = 1'b0; bus0.d = '0;
    bus1.load = 1'b0; bus1.d = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // async reset mid-burst with load held: outputs drop before the next edge
    @(negedge clk);
    bus0.load = 1'b1; bus0.d = 4'b1011;
    bus1.load = 1'b1; bus1.d = 8'h3C;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dout0",  bus0.dout,  1'b0);
    check("async_rst_valid0", bus0.valid, 1'b0);
    check("async_rst_busy0",  bus0.busy,  1'b0);
    check("async_rst_valid1", bus1.valid, 1'b0);
    check("async_rst_busy1",  bus1.busy,  1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus1.load = 1'b0;
    @(negedge clk);
    bus0.load = 1'b0;
    repeat (8) @(negedge clk);

    pulse0(4'b1011, 1);
    repeat (8) @(negedge clk);
    pulse0(4'b0110, 1);
    repeat (8) @(negedge clk);

    // load held through SEND/FIN is ignored, then restarts on the first idle edge
    @(negedge clk);
    bus0.load = 1'b1; bus0.d = 4'b1001;
    @(negedge clk);
    bus0.d = 4'b1111;
    repeat (7) @(negedge clk);
    bus0.load = 1'b0;
    repeat (10) @(negedge clk);

    // reset after the second bit of 1111, then a fresh burst
    pulse0(4'b1111, 1);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse0(4'b0101, 1);
    repeat (8) @(negedge clk);

    // MSB-first 8-bit lane
    @(negedge clk);
    bus1.load = 1'b1; bus1.d = 8'hA5;
    @(negedge clk);
    bus1.load = 1'b0;
    repeat (12) @(negedge clk);

    // random traffic with occasional async resets
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus0.load = ($urandom_range(0, 3) == 0);
      bus0.d    = W0'($urandom);
      bus1.load = ($urandom_range(0, 3) == 0);
      bus1.d    = W1'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    bus0.load = 1'b0;
    bus1.load = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out transmitter for the 4-stage serial-in shift receiver built from PNU_DFF stages.
- Loads a WIDTH-bit word, drives it LSB-first on one serial line, one bit per CLK, and frames the burst with VALID, BUSY and DONE.
- The receiver on the same CLK ends the burst holding D[0] at its Q0 and D[WIDTH-1] at its Q(WIDTH-1), so the word is restored in its original bit order.

Parameters:
- WIDTH, 4, word length in bits; legal range is 2 to 16.
- MSB_FIRST, 0, shift order; 0 sends D[0] first (matches the receiver), 1 sends D[WIDTH-1] first.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- LOAD  input  1  start request; sampled only in IDLE.
- D  input  WIDTH  parallel word; captured on the edge that accepts LOAD.
- Dout  output  1  serial data, connects to the receiver's Din.
- VALID  output  1  high while Dout carries a data bit.
- BUSY  output  1  high while not in IDLE.
- DONE  output  1  one-cycle pulse after the last bit.

Behaviour:
- State register has three states: IDLE, SEND, FIN. Datapath is a WIDTH-bit shift register (sreg) and a bit counter (cnt) of clog2(WIDTH) bits.
- RST high (asynchronous, any time, including mid-burst) forces:
  - state to IDLE, sreg to 0, cnt to 0;
  - Dout, VALID, BUSY and DONE to 0 immediately.
  - RST wins over LOAD. The first LOAD can be accepted on the first rising edge after RST deasserts.
- IDLE:
  - Outputs: Dout=0, VALID=0, BUSY=0, DONE=0.
  - Rising edge with LOAD=1: sreg<=D, cnt<=0, state<=SEND.
  - Rising edge with LOAD=0: remain in IDLE.
- SEND:
  - Outputs: VALID=1, BUSY=1, DONE=0.
  - Dout = sreg[0] when MSB_FIRST=0, sreg[WIDTH-1] when MSB_FIRST=1. Dout is decoded from registered state and carries no combinational path from any input.
  - Each edge with cnt != WIDTH-1: shift sreg one place toward the output end, fill with 0, cnt<=cnt+1.
  - Edge with cnt == WIDTH-1: state<=FIN, sreg<=0.
  - Each bit is held exactly one CLK cycle. The first bit appears in the cycle right after the LOAD edge.
- FIN:
  - Outputs: Dout=0, VALID=0, BUSY=1, DONE=1 for exactly one cycle.
  - Next edge: state<=IDLE.
- LOAD while in SEND or FIN is ignored, with no queuing. D is don't-care outside the accepting edge.
- Throughput:
  - LOAD to DONE is WIDTH+1 cycles.
  - Minimum LOAD-to-LOAD spacing is WIDTH+2 cycles: the first IDLE cycle after FIN can accept.
- Receiver alignment: a receiver on the same CLK holds the full word WIDTH edges after the LOAD edge, i.e. on the edge entering FIN. DONE high therefore marks the cycle in which the receiver's parallel output is valid.
- cnt never exceeds WIDTH-1. There is no wrap-around within a burst.

Test Plan:
- Reset: assert RST asynchronously between edges with LOAD=1 held -> Dout/VALID/BUSY/DONE read 0 before the next edge and stay 0 while RST is high.
- LSB-first burst: WIDTH=4, D=4'b1011, one-cycle LOAD -> Dout over the next 4 cycles is 1,1,0,1 with VALID=1 for those cycles -> DONE=1 in cycle 5 -> BUSY=0 in cycle 6.
- Loopback: connect Dout to the 4-stage receiver's Din, send D=4'b0110 -> on the edge entering FIN the receiver reads Q3..Q0 = 0,1,1,0.
- LOAD ignored while busy: D=4'b1001 loaded, then LOAD=1 with D=4'b1111 during SEND and FIN -> Dout stays 1,0,0,1 and exactly one DONE pulse; with LOAD still high, a new burst starts on the first IDLE edge.
- Mid-burst reset: assert RST after the 2nd bit of D=4'b1111 -> outputs drop to 0 at once, no DONE pulse; after release a fresh LOAD with D=4'b0101 sends 1,0,1,0.
- MSB_FIRST=1, WIDTH=8, D=8'hA5 -> Dout sends 1,0,1,0,0,1,0,1 -> DONE 9 cycles after the LOAD edge.
